// File: rtl/oric_ram_bridge.sv
// Bridges the Oric core RAM strobes onto SDRAM port1 using a toggle handshake.
// Holds one pending request while waiting for an ack, and flags stuck requests with a sticky timeout.
module oric_ram_bridge #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ram_ad,
    input  logic [7:0]  ram_d,
    input  logic        ram_cs,
    input  logic        ram_oe,
    input  logic        ram_we,
    output logic [7:0]  ram_q,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [15:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic        port1_we,
    output logic [15:0] port1_d,
    input  logic [15:0] port1_q,
    output logic        busy,
    output logic        err
);

    localparam logic [CW-1:0] TimeoutCnt = CW'(TIMEOUT);

    typedef enum logic {StIdle, StWait} state_e;
    state_e state_q, state_d;

    logic          rd_old, wr_old;
    logic [15:0]   ad_old;
    logic          rd_rise, wr_rise, ad_chg, trig, cap_we;
    logic          pend_v, pend_we;
    logic [15:0]   pend_a;
    logic [7:0]    pend_d;
    logic [7:0]    data_r;
    logic [CW-1:0] cnt;
    logic          done, take, issue;
    logic          slot_v, slot_we;
    logic [15:0]   slot_a;
    logic [7:0]    slot_d;
    logic [1:0]    issue_ds;

    assign rd_rise = ram_cs & ram_oe & ~rd_old;
    assign wr_rise = ram_cs & ram_we & ~wr_old;
    assign ad_chg  = ram_cs & ram_oe & (ram_ad != ad_old);
    assign trig    = rd_rise | wr_rise | ad_chg;
    assign cap_we  = ram_we & ram_cs;
    assign done    = (state_q == StWait) && (port1_ack == port1_req);

    // Slot contents after folding in this cycle's trigger; a read never displaces a pending write.
    always_comb begin
        take    = trig & (cap_we | ~pend_v | ~pend_we);
        slot_v  = pend_v | trig;
        slot_a  = take ? ram_ad : pend_a;
        slot_d  = take ? ram_d  : pend_d;
        slot_we = take ? cap_we : pend_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    issue   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (done) begin
                    if (slot_v) begin
                        issue = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q == StWait) | pend_v;
        ram_q    = ram_cs ? data_r : 8'h00;
        issue_ds = slot_we ? (slot_a[0] ? 2'b10 : 2'b01) : 2'b11;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Following ack during reset absorbs any late toggle from an abandoned request.
            port1_req <= port1_ack;
            port1_a   <= 16'h0000;
            port1_ds  <= 2'b11;
            port1_we  <= 1'b0;
            port1_d   <= 16'h0000;
            pend_v    <= 1'b0;
            pend_we   <= 1'b0;
            pend_a    <= 16'h0000;
            pend_d    <= 8'h00;
            data_r    <= 8'h00;
            err       <= 1'b0;
            cnt       <= '0;
            rd_old    <= 1'b0;
            wr_old    <= 1'b0;
            ad_old    <= 16'h0000;
        end else begin
            rd_old <= ram_cs & ram_oe;
            wr_old <= ram_cs & ram_we;
            ad_old <= ram_ad;

            if (issue) begin
                port1_a   <= slot_a;
                port1_ds  <= issue_ds;
                port1_we  <= slot_we;
                port1_d   <= {slot_d, slot_d};
                port1_req <= ~port1_req;
                cnt       <= '0;
            end else if ((state_q == StWait) && (cnt != TimeoutCnt)) begin
                cnt <= cnt + 1'b1;
            end

            if ((state_q == StWait) && (cnt == TimeoutCnt)) begin
                err <= 1'b1;
            end

            if (done && !port1_we) begin
                data_r <= port1_a[0] ? port1_q[15:8] : port1_q[7:0];
            end

            if (issue) begin
                pend_v <= 1'b0;
            end else if ((state_q == StWait) && trig) begin
                pend_v <= 1'b1;
                if (take) begin
                    pend_a  <= ram_ad;
                    pend_d  <= ram_d;
                    pend_we <= cap_we;
                end
            end
        end
    end

endmodule

// File: tb/tb_oric_ram_bridge.sv
// Self-checking bench for oric_ram_bridge: a responder models the SDRAM toggle handshake
// and pops expected requests from a scoreboard queue as each req toggle appears.
module tb_oric_ram_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ram_ad;
    logic [7:0]  ram_d;
    logic        ram_cs, ram_oe, ram_we;
    logic [7:0]  ram_q;
    logic        port1_req, port1_ack;
    logic [15:0] port1_a, port1_d, port1_q;
    logic [1:0]  port1_ds;
    logic        port1_we, busy, err;

    int n_checks = 0;
    int n_errors = 0;
    int n_toggles = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int last_gap = 0;
    int ack_dly = 5;
    logic ack_en = 1'b1;
    logic ack_force = 1'b0;
    logic [34:0] sb_q[$];

    oric_ram_bridge #(.TIMEOUT(255), .CW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ram_ad    (ram_ad),
        .ram_d     (ram_d),
        .ram_cs    (ram_cs),
        .ram_oe    (ram_oe),
        .ram_we    (ram_we),
        .ram_q     (ram_q),
        .port1_req (port1_req),
        .port1_ack (port1_ack),
        .port1_a   (port1_a),
        .port1_ds  (port1_ds),
        .port1_we  (port1_we),
        .port1_d   (port1_d),
        .port1_q   (port1_q),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_for(input logic [15:0] a);
        if (a == 16'h1235) return 16'hAB12;
        return {a[7:0] ^ 8'hC3, a[7:0] ^ 8'h3C};
    endfunction

    task automatic expect_req(input logic [15:0] a, input logic [1:0] ds, input logic we,
                              input logic [7:0] d);
        sb_q.push_back({a, ds, we, d, d});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle"}, busy, 0);
        check_eq({tag, "_sb_empty"}, sb_q.size(), 0);
        step(1);
    endtask

    // SDRAM responder: checks each new request against the scoreboard, acks after ack_dly clocks.
    initial begin : responder
        int countdown = 0;
        logic resp_busy = 1'b0;
        logic last_req = 1'b0;
        logic [15:0] resp_a = 16'h0000;
        logic [34:0] exp;
        port1_ack = 1'b0;
        port1_q   = 16'h0000;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_req  = port1_req;
                resp_busy = 1'b0;
                if (ack_force) port1_ack = 1'b1;
            end else begin
                if (resp_busy) begin
                    countdown--;
                    if (countdown == 0) begin
                        port1_q   = word_for(resp_a);
                        port1_ack = port1_req;
                        ack_cyc   = cyc;
                        resp_busy = 1'b0;
                    end
                end
                if (port1_req != last_req) begin
                    last_req = port1_req;
                    n_toggles++;
                    last_gap = cyc - ack_cyc;
                    if (sb_q.size() == 0) begin
                        check_eq("req_unexpected", sb_q.size(), 1);
                    end else begin
                        exp = sb_q.pop_front();
                        check_eq("req", {port1_a, port1_ds, port1_we, port1_d}, exp);
                    end
                    if (ack_en) begin
                        resp_busy = 1'b1;
                        countdown = ack_dly;
                        resp_a    = port1_a;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        int base;
        reset = 1'b1;
        ram_ad = 16'h0000; ram_d = 8'h00;
        ram_cs = 1'b0; ram_oe = 1'b0; ram_we = 1'b0;
        step(3);
        @(negedge clk);
        check_eq("rst_req", port1_req, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ds", port1_ds, 2'b11);
        check_eq("rst_ramq", ram_q, 8'h00);
        step(1);
        reset = 1'b0;
        step(2);

        // Single read of an odd address returns the high byte
        base = n_toggles;
        ram_cs = 1'b1; ram_oe = 1'b1; ram_ad = 16'h1235;
        expect_req(16'h1235, 2'b11, 1'b0, 8'h00);
        wait_idle("read");
        check_eq("read_toggles", n_toggles - base, 1);
        check_eq("read_ramq", ram_q, 8'hAB);

        // Write leaves the read data untouched
        base = n_toggles;
        ram_oe = 1'b0; ram_we = 1'b1; ram_ad = 16'h0400; ram_d = 8'h5A;
        expect_req(16'h0400, 2'b01, 1'b1, 8'h5A);
        wait_idle("write");
        check_eq("write_toggles", n_toggles - base, 1);
        check_eq("write_ramq", ram_q, 8'hAB);
        ram_we = 1'b0;
        step(2);

        // Write then read two clocks later, slow ack
        ack_dly = 10;
        base = n_toggles;
        ram_we = 1'b1; ram_ad = 16'h0401; ram_d = 8'h77;
        expect_req(16'h0401, 2'b10, 1'b1, 8'h77);
        step(2);
        ram_we = 1'b0; ram_oe = 1'b1; ram_ad = 16'h0402;
        expect_req(16'h0402, 2'b11, 1'b0, 8'h77);
        wait_idle("b2b");
        check_eq("b2b_toggles", n_toggles - base, 2);
        check_eq("b2b_gap", last_gap, 1);
        check_eq("b2b_ramq", ram_q, 8'h3E);
        ram_oe = 1'b0;
        step(2);

        // Pending write must survive a later read trigger
        base = n_toggles;
        ram_oe = 1'b1; ram_ad = 16'h0030;
        expect_req(16'h0030, 2'b11, 1'b0, 8'h77);
        step(1);
        ram_oe = 1'b0;
        step(1);
        ram_we = 1'b1; ram_ad = 16'h0010; ram_d = 8'h11;
        expect_req(16'h0010, 2'b01, 1'b1, 8'h11);
        step(1);
        ram_we = 1'b0;
        step(1);
        ram_oe = 1'b1; ram_ad = 16'h0020;
        step(1);
        ram_oe = 1'b0;
        wait_idle("prio");
        check_eq("prio_toggles", n_toggles - base, 2);
        check_eq("prio_gap", last_gap, 1);
        check_eq("prio_ramq", ram_q, 8'h0C);
        step(2);

        // Address change with oe held
        ack_dly = 3;
        base = n_toggles;
        ram_oe = 1'b1; ram_ad = 16'h2000;
        expect_req(16'h2000, 2'b11, 1'b0, 8'h11);
        wait_idle("adchg0");
        check_eq("adchg0_ramq", ram_q, 8'h3C);
        ram_ad = 16'h2001;
        expect_req(16'h2001, 2'b11, 1'b0, 8'h11);
        wait_idle("adchg1");
        check_eq("adchg1_ramq", ram_q, 8'hC2);
        check_eq("adchg_toggles", n_toggles - base, 2);
        ram_cs = 1'b0;
        @(negedge clk);
        check_eq("cs_low_ramq", ram_q, 8'h00);
        step(1);
        ram_oe = 1'b0; ram_cs = 1'b1;
        step(2);

        // Ack never returns
        ack_en = 1'b0;
        base = n_toggles;
        ram_oe = 1'b1; ram_ad = 16'h3000;
        expect_req(16'h3000, 2'b11, 1'b0, 8'h11);
        repeat (100) @(negedge clk);
        check_eq("to_err_early", err, 0);
        check_eq("to_busy", busy, 1);
        repeat (170) @(negedge clk);
        check_eq("to_err", err, 1);
        check_eq("to_toggles", n_toggles - base, 1);

        // Reset with ack high resyncs req
        step(1);
        ack_force = 1'b1; reset = 1'b1; ram_oe = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst2_req", port1_req, 1);
        check_eq("rst2_err", err, 0);
        check_eq("rst2_busy", busy, 0);
        step(1);
        reset = 1'b0; ack_force = 1'b0; ack_en = 1'b1; ack_dly = 4;
        step(1);
        base = n_toggles;
        ram_oe = 1'b1; ram_ad = 16'h3002;
        expect_req(16'h3002, 2'b11, 1'b0, 8'h11);
        wait_idle("post_rst");
        check_eq("post_rst_req", port1_req, 0);
        check_eq("post_rst_toggles", n_toggles - base, 1);
        check_eq("post_rst_ramq", ram_q, 8'h3E);
        check_eq("post_rst_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
